// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared types, widths and defaults for the instruction-fetch sequencer.
// Imported by the sequencer top and its PC adder.
package pc_fetch_sequencer_pkg;

   localparam int unsigned PC_W   = 32;
   localparam int unsigned INST_W = 32;

   localparam logic [PC_W-1:0] RESET_PC_DEF = 32'h0000_0000;
   localparam logic [PC_W-1:0] PC_STEP_DEF  = 32'd4;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_WAIT  = 2'd1,
      ST_DROP  = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic [INST_W-1:0] data;
   } inst_buf_t;

   // Instruction addresses are word aligned; the low two bits are never honoured.
   function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
      return pc & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/pc_fetch_sequencer_adder.sv
// 32-bit PC adder used for sequential next-PC generation.
// Pure combinational; the sum wraps modulo 2^32 with no carry out.
module pc_fetch_sequencer_adder
   import pc_fetch_sequencer_pkg::*;
(
   input  logic [PC_W-1:0] i_a,
   input  logic [PC_W-1:0] i_b,
   output logic [PC_W-1:0] o_sum
);

   assign o_sum = i_a + i_b;

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Fetch sequencer: owns the architectural PC, issues one imem read at a time and
// presents {pc, instruction} to decode through a one-entry valid/ready buffer.
module pc_fetch_sequencer
   import pc_fetch_sequencer_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF,
   parameter logic [PC_W-1:0] PC_STEP  = PC_STEP_DEF
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_redirect_valid,
   input  logic [PC_W-1:0]   i_redirect_pc,
   output logic              o_imem_req,
   output logic [PC_W-1:0]   o_imem_addr,
   input  logic              i_imem_ack,
   input  logic [INST_W-1:0] i_imem_rdata,
   output logic              o_inst_valid,
   output logic [PC_W-1:0]   o_inst_pc,
   output logic [INST_W-1:0] o_inst_data,
   input  logic              i_inst_ready
);

   fetch_state_t    r_state;
   logic [PC_W-1:0] r_pc;
   logic [PC_W-1:0] r_req_addr;
   logic            r_imem_req;
   logic            r_inst_valid;
   inst_buf_t       r_buf;

   logic [PC_W-1:0] w_pc_next;
   logic [PC_W-1:0] w_redirect_pc;

   assign w_redirect_pc = align_pc(i_redirect_pc);

   pc_fetch_sequencer_adder u_adder_pc (
      .i_a   (r_pc),
      .i_b   (PC_STEP),
      .o_sum (w_pc_next)
   );

   // Every transition back into FETCH issues the next read directly, so the
   // request rises in the cycle after an ack, handshake or flush.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= ST_FETCH;
         r_pc         <= RESET_PC;
         r_req_addr   <= '0;
         r_imem_req   <= 1'b0;
         r_inst_valid <= 1'b0;
         r_buf        <= '0;
      end else begin
         case (r_state)
            ST_FETCH: begin
               if (i_redirect_valid) begin
                  r_pc <= w_redirect_pc;
                  if (r_imem_req && !i_imem_ack) begin
                     r_state <= ST_DROP;
                  end else begin
                     r_imem_req <= 1'b1;
                     r_req_addr <= w_redirect_pc;
                  end
               end else if (!r_imem_req) begin
                  r_imem_req <= 1'b1;
                  r_req_addr <= r_pc;
               end else if (i_imem_ack) begin
                  r_buf.pc     <= r_req_addr;
                  r_buf.data   <= i_imem_rdata;
                  r_inst_valid <= 1'b1;
                  r_pc         <= w_pc_next;
                  r_imem_req   <= 1'b0;
                  r_state      <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (i_redirect_valid) begin
                  r_pc         <= w_redirect_pc;
                  r_inst_valid <= 1'b0;
                  r_imem_req   <= 1'b1;
                  r_req_addr   <= w_redirect_pc;
                  r_state      <= ST_FETCH;
               end else if (r_inst_valid && i_inst_ready) begin
                  r_inst_valid <= 1'b0;
                  r_imem_req   <= 1'b1;
                  r_req_addr   <= r_pc;
                  r_state      <= ST_FETCH;
               end
            end
            ST_DROP: begin
               // The stale read must still complete; its data is never buffered.
               if (i_redirect_valid) begin
                  r_pc <= w_redirect_pc;
               end
               if (i_imem_ack) begin
                  r_req_addr <= i_redirect_valid ? w_redirect_pc : r_pc;
                  r_state    <= ST_FETCH;
               end
            end
            default: begin
               r_state    <= ST_FETCH;
               r_imem_req <= 1'b0;
            end
         endcase
      end
   end

   assign o_imem_req   = r_imem_req;
   assign o_imem_addr  = r_req_addr;
   assign o_inst_valid = r_inst_valid;
   assign o_inst_pc    = r_buf.pc;
   assign o_inst_data  = r_buf.data;

endmodule
